// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 control logic and the IRR block.
package pic_pkg;

    typedef enum logic [1:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW4,
        READY
    } init_state_e;

    typedef enum logic [2:0] {
        A_IDLE,
        A_FIRST,
        A_GAP,
        A_SECOND,
        A_END
    } inta_state_e;

    localparam logic [2:0] EOI_NONSPEC = 3'b001;
    localparam logic [2:0] EOI_SPEC    = 3'b011;

    // Index of the lowest set bit (IR0 = highest priority); 7 when v is empty.
    function automatic logic [2:0] lowest_set_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] level_onehot(input logic [2:0] l);
        return 8'b1 << l;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver: unmasked requests strictly above the highest in-service level.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [7:0] isr,
    output logic       valid,
    output logic [2:0] level
);

    logic [7:0] isr_lowest;
    logic [7:0] below_mask;
    logic [7:0] eligible;

    // Isolating the lowest ISR bit and subtracting one gives every lower index;
    // an empty ISR wraps to all ones, leaving every level eligible.
    assign isr_lowest = isr & (~isr + 8'd1);
    assign below_mask = isr_lowest - 8'd1;
    assign eligible   = irr & ~imr & below_mask;

    assign valid = |eligible;
    assign level = lowest_set_bit(eligible);

endmodule

// File: rtl/pic_control_logic.sv
// 8259 command registers, IMR/ISR, interrupt request and the 8086 two-pulse INTA sequencer.
module pic_control_logic
    import pic_pkg::*;
#(
    parameter int NUM_IR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        internal_bus,
    input  logic              write_ICW_1,
    input  logic              write_ICW2,
    input  logic              write_ICW4,
    input  logic              write_OCW1,
    input  logic              write_OCW2,
    input  logic              write_OCW3,
    input  logic              read,
    input  logic              A1,
    input  logic [NUM_IR-1:0] irr,
    input  logic              INTA_n,
    output logic [NUM_IR-1:0] irr_clear,
    output logic              INT,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [NUM_IR-1:0] imr,
    output logic [NUM_IR-1:0] isr,
    output logic              init_done
);

    init_state_e init_q, init_d;
    inta_state_e a_q, a_d;
    logic        ic4_q, ic4_d;
    logic [4:0]  icw2_q, icw2_d;
    logic        aeoi_q, aeoi_d;
    logic        rsel_q, rsel_d;
    logic [7:0]  imr_q, imr_d;
    logic [7:0]  isr_q, isr_d;
    logic [2:0]  level_q, level_d;
    logic        spur_q, spur_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic [7:0]  irr_clear_q, irr_clear_d;
    logic        int_q, int_d;
    logic        inta_prev_q;

    logic        ready, inta_fall, inta_rise, res_valid;
    logic [2:0]  res_level;
    logic [7:0]  eoi_clear, inta_set;

    pic_priority_resolver u_resolver (
        .irr   (irr),
        .imr   (imr_q),
        .isr   (isr_q),
        .valid (res_valid),
        .level (res_level)
    );

    assign ready     = (init_q == READY);
    assign inta_fall = inta_prev_q & ~INTA_n;
    assign inta_rise = ~inta_prev_q & INTA_n;

    always_comb begin
        init_d      = init_q;
        a_d         = a_q;
        ic4_d       = ic4_q;
        icw2_d      = icw2_q;
        aeoi_d      = aeoi_q;
        rsel_d      = rsel_q;
        imr_d       = imr_q;
        level_d     = level_q;
        spur_d      = spur_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        irr_clear_d = '0;
        eoi_clear   = '0;
        inta_set    = '0;

        case (init_q)
            WAIT_ICW2: if (write_ICW2) begin
                icw2_d = internal_bus[7:3];
                init_d = ic4_q ? WAIT_ICW4 : READY;
            end
            WAIT_ICW4: if (write_ICW4) begin
                aeoi_d = internal_bus[1];
                init_d = READY;
            end
            default: ;
        endcase

        if (ready && write_OCW1) imr_d = internal_bus;
        if (ready && write_OCW2) begin
            if (internal_bus[7:5] == EOI_NONSPEC)
                eoi_clear = isr_q & level_onehot(lowest_set_bit(isr_q));
            else if (internal_bus[7:5] == EOI_SPEC)
                eoi_clear = level_onehot(internal_bus[2:0]);
        end
        if (ready && write_OCW3 && internal_bus[1]) rsel_d = internal_bus[0];

        case (a_q)
            A_IDLE: begin
                data_oe_d = read;
                if (read) data_out_d = A1 ? imr_q : (rsel_q ? isr_q : irr);
                if (ready && inta_fall) begin
                    a_d       = A_FIRST;
                    data_oe_d = 1'b0;
                    spur_d    = ~res_valid;
                    level_d   = res_valid ? res_level : 3'd7;
                    if (res_valid) inta_set = level_onehot(res_level);
                    irr_clear_d = inta_set;
                end
            end
            A_FIRST: begin
                data_oe_d = 1'b0;
                if (ready && inta_rise) a_d = A_GAP;
            end
            A_GAP: begin
                data_oe_d = 1'b0;
                if (ready && inta_fall) begin
                    a_d        = A_SECOND;
                    data_oe_d  = 1'b1;
                    data_out_d = {icw2_q, level_q};
                end
            end
            A_SECOND: if (ready && inta_rise) begin
                a_d       = A_END;
                data_oe_d = 1'b0;
                if (aeoi_q && !spur_q) eoi_clear = eoi_clear | level_onehot(level_q);
            end
            A_END: begin
                a_d       = A_IDLE;
                data_oe_d = 1'b0;
            end
            default: a_d = A_IDLE;
        endcase

        isr_d = (isr_q & ~eoi_clear) | inta_set;

        // ICW1 restarts initialization and overrides everything decided above.
        if (write_ICW_1) begin
            init_d      = WAIT_ICW2;
            ic4_d       = internal_bus[0];
            imr_d       = '0;
            isr_d       = '0;
            aeoi_d      = 1'b0;
            rsel_d      = 1'b0;
            a_d         = A_IDLE;
            data_oe_d   = 1'b0;
            irr_clear_d = '0;
        end

        int_d = (init_d == READY) && res_valid && (a_d == A_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q      <= UNINIT;
            a_q         <= A_IDLE;
            ic4_q       <= 1'b0;
            icw2_q      <= '0;
            aeoi_q      <= 1'b0;
            rsel_q      <= 1'b0;
            imr_q       <= '0;
            isr_q       <= '0;
            level_q     <= '0;
            spur_q      <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            irr_clear_q <= '0;
            int_q       <= 1'b0;
            inta_prev_q <= 1'b0;
        end else begin
            init_q      <= init_d;
            a_q         <= a_d;
            ic4_q       <= ic4_d;
            icw2_q      <= icw2_d;
            aeoi_q      <= aeoi_d;
            rsel_q      <= rsel_d;
            imr_q       <= imr_d;
            isr_q       <= isr_d;
            level_q     <= level_d;
            spur_q      <= spur_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            irr_clear_q <= irr_clear_d;
            int_q       <= int_d;
            inta_prev_q <= INTA_n;
        end
    end

    assign irr_clear = irr_clear_q;
    assign INT       = int_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign imr       = imr_q;
    assign isr       = isr_q;
    assign init_done = (init_q == READY);

endmodule

// File: tb/tb_pic_control_logic.sv
// Bench for pic_control_logic: directed scenarios plus randomized acknowledge/EOI/read rounds.
module tb_pic_control_logic;

    logic       clk, reset;
    logic [7:0] internal_bus;
    logic       write_ICW_1, write_ICW2, write_ICW4;
    logic       write_OCW1, write_OCW2, write_OCW3;
    logic       read, A1, INTA_n;
    logic [7:0] irr;
    logic [7:0] irr_clear, data_out, imr, isr;
    logic       INT, data_oe, init_done;

    int total = 0;
    int bad   = 0;

    localparam int S_ICW1 = 0, S_ICW2 = 1, S_ICW4 = 2, S_OCW1 = 3, S_OCW2 = 4, S_OCW3 = 5;

    // reference state
    logic [7:0] m_imr, m_isr, m_icw2;
    logic       m_aeoi, m_rsel;

    pic_control_logic #(.NUM_IR(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .internal_bus (internal_bus),
        .write_ICW_1  (write_ICW_1),
        .write_ICW2   (write_ICW2),
        .write_ICW4   (write_ICW4),
        .write_OCW1   (write_OCW1),
        .write_OCW2   (write_OCW2),
        .write_OCW3   (write_OCW3),
        .read         (read),
        .A1           (A1),
        .irr          (irr),
        .INTA_n       (INTA_n),
        .irr_clear    (irr_clear),
        .INT          (INT),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .imr          (imr),
        .isr          (isr),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest-priority eligible level by the priority rules, or -1 when none.
    function automatic int model_level(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
        int lim;
        lim = 8;
        for (int i = 7; i >= 0; i--) if (s[i]) lim = i;
        for (int i = 0; i < lim; i++) if (r[i] && !m[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int which, input logic [7:0] val);
        internal_bus = val;
        case (which)
            S_ICW1:  write_ICW_1 = 1'b1;
            S_ICW2:  write_ICW2  = 1'b1;
            S_ICW4:  write_ICW4  = 1'b1;
            S_OCW1:  write_OCW1  = 1'b1;
            S_OCW2:  write_OCW2  = 1'b1;
            default: write_OCW3  = 1'b1;
        endcase
        tick();
        {write_ICW_1, write_ICW2, write_ICW4, write_OCW1, write_OCW2, write_OCW3} = '0;
    endtask

    task automatic do_reset();
        {write_ICW_1, write_ICW2, write_ICW4, write_OCW1, write_OCW2, write_OCW3} = '0;
        internal_bus = 8'h00;
        read = 1'b0; A1 = 1'b0; INTA_n = 1'b1; irr = 8'h00;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        m_imr = 0; m_isr = 0; m_icw2 = 0; m_aeoi = 0; m_rsel = 0;
    endtask

    task automatic init_seq(input logic [7:0] icw1, input logic [7:0] icw2, input logic [7:0] icw4);
        strobe(S_ICW1, icw1);
        strobe(S_ICW2, icw2);
        if (icw1[0]) strobe(S_ICW4, icw4);
        m_imr = 0; m_isr = 0; m_rsel = 0; m_icw2 = icw2;
        m_aeoi = icw1[0] ? icw4[1] : 1'b0;
    endtask

    // Full two-pulse acknowledge; the bench plays the IRR block by clearing the acknowledged bit.
    task automatic do_ack(output logic [7:0] clr, output logic [7:0] isr1,
                          output logic [7:0] vec, output logic oe);
        INTA_n = 1'b0; tick();
        clr = irr_clear; isr1 = isr;
        irr = irr & ~irr_clear;
        tick();
        INTA_n = 1'b1; tick();
        INTA_n = 1'b0; tick();
        oe = data_oe; vec = data_out;
        INTA_n = 1'b1; tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {write_ICW_1, write_ICW2, write_ICW4, write_OCW1, write_OCW2, write_OCW3} = '0;
        internal_bus = 8'h00; read = 1'b0; A1 = 1'b0; INTA_n = 1'b1; irr = 8'hFF;
        tick(); tick();
        total++;
        if ({INT, data_oe, data_out, irr_clear, imr, isr, init_done} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {INT, data_oe, data_out, irr_clear, imr, isr, init_done});
        end
        reset = 1'b1; tick();
        total++;
        if (init_done !== 1'b0) begin bad++; $display("FAIL reset_uninit got=%b exp=0", init_done); end
    endtask

    task automatic test_init();
        do_reset();
        strobe(S_ICW1, 8'h13);
        strobe(S_ICW2, 8'h40);
        total++;
        if (init_done !== 1'b0) begin bad++; $display("FAIL init_wait_icw4 got=%b exp=0", init_done); end
        strobe(S_ICW4, 8'h03);
        total++;
        if (init_done !== 1'b1) begin bad++; $display("FAIL init_after_icw4 got=%b exp=1", init_done); end
        do_reset();
        strobe(S_OCW1, 8'h55);
        total++;
        if (imr !== 8'h00) begin bad++; $display("FAIL ocw_before_ready got=%h exp=00", imr); end
        strobe(S_ICW1, 8'h12);
        strobe(S_ICW2, 8'h40);
        total++;
        if (init_done !== 1'b1) begin bad++; $display("FAIL init_no_icw4 got=%b exp=1", init_done); end
    endtask

    task automatic test_aeoi_ack();
        do_reset();
        init_seq(8'h13, 8'h40, 8'h03);
        irr = 8'h24; tick();
        total++;
        if (INT !== 1'b1) begin bad++; $display("FAIL aeoi_int got=%b exp=1", INT); end
        INTA_n = 1'b0; tick();
        total++;
        if (irr_clear !== 8'h04 || isr !== 8'h04 || INT !== 1'b0) begin
            bad++; $display("FAIL aeoi_first got clr=%h isr=%h int=%b exp 04 04 0", irr_clear, isr, INT);
        end
        irr = 8'h20; tick();
        total++;
        if (irr_clear !== 8'h00) begin bad++; $display("FAIL aeoi_clr_pulse got=%h exp=00", irr_clear); end
        INTA_n = 1'b1; tick();
        INTA_n = 1'b0; tick();
        total++;
        if (data_oe !== 1'b1 || data_out !== 8'h42) begin
            bad++; $display("FAIL aeoi_vector got oe=%b d=%h exp 1 42", data_oe, data_out);
        end
        INTA_n = 1'b1; tick();
        total++;
        if (isr !== 8'h00 || data_oe !== 1'b0) begin
            bad++; $display("FAIL aeoi_end got isr=%h oe=%b exp 00 0", isr, data_oe);
        end
        tick();
        total++;
        if (INT !== 1'b1) begin bad++; $display("FAIL aeoi_next_int got=%b exp=1", INT); end
    endtask

    task automatic test_priority_eoi_read();
        logic [7:0] clr, isr1, vec;
        logic oe;
        do_reset();
        init_seq(8'h12, 8'h40, 8'h00);
        strobe(S_ICW4, 8'h02);
        irr = 8'h04; tick(); tick();
        do_ack(clr, isr1, vec, oe);
        total++;
        if (isr !== 8'h04) begin bad++; $display("FAIL no_aeoi_isr got=%h exp=04", isr); end
        irr = 8'h10; tick(); tick();
        total++;
        if (INT !== 1'b0) begin bad++; $display("FAIL prio_block got=%b exp=0", INT); end
        strobe(S_OCW2, 8'h20);
        total++;
        if (isr !== 8'h00) begin bad++; $display("FAIL nonspec_eoi got=%h exp=00", isr); end
        tick();
        total++;
        if (INT !== 1'b1) begin bad++; $display("FAIL prio_unblock got=%b exp=1", INT); end
        do_ack(clr, isr1, vec, oe);
        total++;
        if (vec !== 8'h44 || isr !== 8'h10) begin
            bad++; $display("FAIL ack_ir4 got vec=%h isr=%h exp 44 10", vec, isr);
        end
        strobe(S_OCW1, 8'hFF);
        irr = 8'h01; tick(); tick();
        total++;
        if (INT !== 1'b0) begin bad++; $display("FAIL masked_int got=%b exp=0", INT); end
        read = 1'b1; A1 = 1'b1; tick();
        total++;
        if (data_oe !== 1'b1 || data_out !== 8'hFF) begin
            bad++; $display("FAIL read_imr got oe=%b d=%h exp 1 ff", data_oe, data_out);
        end
        A1 = 1'b0; tick();
        total++;
        if (data_out !== 8'h01) begin bad++; $display("FAIL read_irr got=%h exp=01", data_out); end
        read = 1'b0; tick();
        total++;
        if (data_oe !== 1'b0) begin bad++; $display("FAIL read_drop got=%b exp=0", data_oe); end
        strobe(S_OCW3, 8'h0B);
        read = 1'b1; tick();
        total++;
        if (data_out !== 8'h10) begin bad++; $display("FAIL read_isr got=%h exp=10", data_out); end
        read = 1'b0; tick();
    endtask

    task automatic test_spurious();
        logic [7:0] clr, isr1, vec;
        logic oe;
        do_reset();
        init_seq(8'h13, 8'h40, 8'h01);
        irr = 8'h08; tick(); tick();
        total++;
        if (INT !== 1'b1) begin bad++; $display("FAIL spur_int got=%b exp=1", INT); end
        irr = 8'h00;
        do_ack(clr, isr1, vec, oe);
        total++;
        if (clr !== 8'h00 || isr1 !== 8'h00 || vec !== 8'h47 || oe !== 1'b1) begin
            bad++; $display("FAIL spurious got clr=%h isr=%h vec=%h oe=%b exp 00 00 47 1", clr, isr1, vec, oe);
        end
    endtask

    task automatic test_icw1_abort();
        do_reset();
        init_seq(8'h13, 8'h40, 8'h03);
        irr = 8'h02; tick(); tick();
        INTA_n = 1'b0; tick();
        INTA_n = 1'b1; tick();
        strobe(S_ICW1, 8'h12);
        total++;
        if (isr !== 8'h00 || init_done !== 1'b0) begin
            bad++; $display("FAIL abort_state got isr=%h done=%b exp 00 0", isr, init_done);
        end
        INTA_n = 1'b0; tick();
        total++;
        if (data_oe !== 1'b0) begin bad++; $display("FAIL abort_no_vector got=%b exp=0", data_oe); end
        INTA_n = 1'b1; tick();
        strobe(S_ICW2, 8'h48);
        total++;
        if (init_done !== 1'b1) begin bad++; $display("FAIL abort_wait_icw2 got=%b exp=1", init_done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        init_seq(8'h13, 8'h40, 8'h01);
        strobe(S_OCW1, 8'hF0);
        irr = 8'h01; tick(); tick();
        INTA_n = 1'b0; tick();
        INTA_n = 1'b1; tick();
        INTA_n = 1'b0; tick();
        total++;
        if (data_oe !== 1'b1) begin bad++; $display("FAIL mid_second got=%b exp=1", data_oe); end
        reset = 1'b0;
        #1;
        total++;
        if ({INT, data_oe, data_out, irr_clear, imr, isr, init_done} !== 35'd0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", {INT, data_oe, data_out, irr_clear, imr, isr, init_done});
        end
        INTA_n = 1'b1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] clr, isr1, vec, exp_clr, exp_isr, exp_vec, exp_rd, bus;
        logic oe, aeoi, exp_int;
        int lvl, sel, l;
        for (int it = 0; it < 24; it++) begin
            do_reset();
            aeoi = 1'($urandom_range(0, 1));
            init_seq(8'h13, 8'($urandom), aeoi ? 8'h03 : 8'h01);
            m_imr = 8'($urandom) & 8'($urandom);
            strobe(S_OCW1, m_imr);
            for (int k = 0; k < 2; k++) begin
                irr = 8'($urandom);
                tick(); tick();
                lvl = model_level(irr, m_imr, m_isr);
                exp_int = (lvl >= 0);
                total++;
                if (INT !== exp_int) begin bad++; $display("FAIL rnd_int got=%b exp=%b", INT, exp_int); end
                do_ack(clr, isr1, vec, oe);
                if (lvl < 0) begin
                    exp_clr = 8'h00;
                    exp_isr = m_isr;
                    exp_vec = {m_icw2[7:3], 3'd7};
                end else begin
                    exp_clr = 8'(1 << lvl);
                    exp_isr = m_isr | exp_clr;
                    exp_vec = {m_icw2[7:3], 3'(lvl)};
                end
                total++;
                if (clr !== exp_clr || isr1 !== exp_isr || vec !== exp_vec || oe !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_ack got clr=%h isr=%h vec=%h oe=%b exp %h %h %h 1",
                             clr, isr1, vec, oe, exp_clr, exp_isr, exp_vec);
                end
                if (lvl >= 0 && !aeoi) m_isr = exp_isr;
                total++;
                if (isr !== m_isr) begin bad++; $display("FAIL rnd_isr_end got=%h exp=%h", isr, m_isr); end
            end
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                bus = 8'h20;
                for (int i = 0; i < 8; i++) if (m_isr[i]) begin m_isr[i] = 1'b0; break; end
            end else if (sel == 1) begin
                l = $urandom_range(0, 7);
                bus = 8'h60 | 8'(l);
                m_isr[l] = 1'b0;
            end else begin
                bus = 8'hA0 | 8'($urandom_range(0, 7));
            end
            strobe(S_OCW2, bus);
            total++;
            if (isr !== m_isr) begin bad++; $display("FAIL rnd_eoi bus=%h got=%h exp=%h", bus, isr, m_isr); end
            bus = 8'h08 | 8'($urandom_range(0, 3));
            strobe(S_OCW3, bus);
            if (bus[1]) m_rsel = bus[0];
            A1 = 1'($urandom_range(0, 1));
            read = 1'b1;
            tick();
            exp_rd = A1 ? m_imr : (m_rsel ? m_isr : irr);
            total++;
            if (data_oe !== 1'b1 || data_out !== exp_rd) begin
                bad++; $display("FAIL rnd_read a1=%b got oe=%b d=%h exp 1 %h", A1, data_oe, data_out, exp_rd);
            end
            read = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_aeoi_ack();
        test_priority_eoi_read();
        test_spurious();
        test_icw1_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
